// File: rtl/dp_ram_pkg.sv
// Shared constants and clear-sequencer state type for the blob-labelling
// line/label RAM family.
package dp_ram_pkg;

  localparam int unsigned COLW  = 14;
  localparam int unsigned ROWW  = 12;
  localparam int unsigned WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } seq_state_t;

endpackage

// File: rtl/dp_ram_clr_seq.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1 once per request, exposing a
// write strobe/address that the RAM top muxes over port A.
module dp_ram_clr_seq
  import dp_ram_pkg::*;
#(
  parameter int unsigned AW         = COLW,
  parameter int unsigned DEPTH      = 1 << AW,
  parameter bit          CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // One extra counter bit keeps DEPTH == 2**AW free of wrap ambiguity.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  seq_state_t  state;
  logic [AW:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLR_ON_RST ? ST_SWEEP : ST_IDLE;
      cnt      <= '0;
      clr_busy <= CLR_ON_RST;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          // Requests arriving mid-sweep are ignored: no restart, no extension.
          if (cnt == LAST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_SWEEP);
  assign clr_addr = cnt[AW-1:0];

endmodule

// File: rtl/dp_ram_clr.sv
// Simple dual-port RAM (write port A, registered read port B) with optional
// write-first bypass and a hardware clear sweep for frame re-initialisation.
module dp_ram_clr
  import dp_ram_pkg::*;
#(
  parameter int unsigned    AW         = COLW,
  parameter int unsigned    DW         = WIDTH,
  parameter int unsigned    DEPTH      = 1 << AW,
  parameter logic [DW-1:0]  CLR_VAL    = '0,
  parameter bit             CLR_ON_RST = 1'b1,
  parameter bit             BYPASS     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addra,
  input  logic          wea,
  input  logic [DW-1:0] dina,
  input  logic          rdb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb,
  output logic          doutb_vld,
  input  logic          clr_req,
  output logic          clr_busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          a_ok;
  logic          b_ok;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  dp_ram_clr_seq #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign a_ok = ({1'b0, addra} < DEPTH_W);
  assign b_ok = ({1'b0, addrb} < DEPTH_W);

  // Sweep owns the write port while busy; port A writes are dropped then.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!rst) begin
      if (clr_we) begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        mem_din  = CLR_VAL;
      end else if (wea && a_ok) begin
        mem_we   = 1'b1;
        mem_addr = addra;
        mem_din  = dina;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doutb     <= '0;
      doutb_vld <= 1'b0;
    end else begin
      doutb_vld <= 1'b0;
      if (rdb && !clr_busy) begin
        doutb_vld <= 1'b1;
        if (!b_ok) begin
          doutb <= '0;
        end else if (BYPASS && wea && (addra == addrb)) begin
          doutb <= dina;
        end else begin
          doutb <= mem[addrb];
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_ram_clr.sv
// Bench for dp_ram_clr: DUT 0 is DEPTH=16/BYPASS/auto-clear, DUT 1 is
// DEPTH=12/read-first/no auto-clear with a non-zero clear value.
module tb_dp_ram_clr;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic       wea     [2];
  logic       rdb     [2];
  logic       clr_req [2];
  logic [3:0] addra   [2];
  logic [3:0] addrb   [2];
  logic [7:0] dina    [2];
  logic [7:0] doutb   [2];
  logic       doutb_vld [2];
  logic       clr_busy  [2];

  int vectors = 0;
  int errors  = 0;

  dp_ram_clr #(
    .AW(4), .DW(8), .DEPTH(16), .CLR_VAL(8'h00), .CLR_ON_RST(1'b1), .BYPASS(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .addra(addra[0]), .wea(wea[0]), .dina(dina[0]),
    .rdb(rdb[0]), .addrb(addrb[0]), .doutb(doutb[0]), .doutb_vld(doutb_vld[0]),
    .clr_req(clr_req[0]), .clr_busy(clr_busy[0])
  );

  dp_ram_clr #(
    .AW(4), .DW(8), .DEPTH(12), .CLR_VAL(8'h5A), .CLR_ON_RST(1'b0), .BYPASS(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .addra(addra[1]), .wea(wea[1]), .dina(dina[1]),
    .rdb(rdb[1]), .addrb(addrb[1]), .doutb(doutb[1]), .doutb_vld(doutb_vld[1]),
    .clr_req(clr_req[1]), .clr_busy(clr_busy[1])
  );

  // Reference model: memory image plus "next address to clear" (-1 = idle).
  logic [7:0] mdl [2][16];
  int         sweep [2];
  logic [7:0] exp_dout [2];
  logic       exp_vld  [2];
  logic       exp_busy [2];

  function automatic int dep(int d);       return (d == 0) ? 16 : 12; endfunction
  function automatic bit byp(int d);       return (d == 0); endfunction
  function automatic bit clr_on_rst(int d); return (d == 0); endfunction
  function automatic logic [7:0] clr_val(int d); return (d == 0) ? 8'h00 : 8'h5A; endfunction

  task automatic model_step(input int d);
    if (rst[d]) begin
      exp_dout[d] = 8'h00;
      exp_vld[d]  = 1'b0;
      sweep[d]    = clr_on_rst(d) ? 0 : -1;
    end else begin
      if (rdb[d] && sweep[d] < 0) begin
        exp_vld[d] = 1'b1;
        if (int'(addrb[d]) >= dep(d)) exp_dout[d] = 8'h00;
        else if (byp(d) && wea[d] && addra[d] == addrb[d]) exp_dout[d] = dina[d];
        else exp_dout[d] = mdl[d][addrb[d]];
      end else begin
        exp_vld[d] = 1'b0;
      end
      if (sweep[d] >= 0) begin
        mdl[d][sweep[d]] = clr_val(d);
        sweep[d]++;
        if (sweep[d] == dep(d)) sweep[d] = -1;
      end else begin
        if (wea[d] && int'(addra[d]) < dep(d)) mdl[d][addra[d]] = dina[d];
        if (clr_req[d]) sweep[d] = 0;
      end
    end
    exp_busy[d] = (sweep[d] >= 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    wea[d] = 1'b0; rdb[d] = 1'b0; clr_req[d] = 1'b0;
    addra[d] = '0; addrb[d] = '0; dina[d] = '0;
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (doutb[d] !== 8'h00 || doutb_vld[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got %h/%b expected 00/0", d, doutb[d], doutb_vld[d]);
      end
      vectors++;
      if (clr_busy[d] !== clr_on_rst(d)) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got %b expected %b", d, clr_busy[d], clr_on_rst(d));
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    begin
      int n = 0;
      while (clr_busy[0] === 1'b1 && n < 64) begin n++; tick(); end
      vectors++;
      if (n != 16) begin
        errors++;
        $display("FAIL auto_clr_width: got %0d cycles expected 16", n);
      end
    end
    for (int i = 0; i < 16; i++) begin
      rdb[0] = 1'b1; addrb[0] = 4'(i);
      tick();
      vectors++;
      if (doutb_vld[0] !== 1'b1 || doutb[0] !== 8'h00) begin
        errors++;
        $display("FAIL clr_read[%0d]: got %h/%b expected 00/1", i, doutb[0], doutb_vld[0]);
      end
    end
    rdb[0] = 1'b0;
    // DUT 1 has no auto-clear: sweep it once by request; width must be 12.
    clr_req[1] = 1'b1;
    tick();
    clr_req[1] = 1'b0;
    begin
      int n = 0;
      while (clr_busy[1] === 1'b1 && n < 64) begin n++; tick(); end
      vectors++;
      if (n != 12) begin
        errors++;
        $display("FAIL req_clr_width12: got %0d cycles expected 12", n);
      end
    end
  endtask

  task automatic test_write_read();
    wea[0] = 1'b1; addra[0] = 4'd3; dina[0] = 8'hA5;
    tick();
    wea[0] = 1'b0; rdb[0] = 1'b1; addrb[0] = 4'd3;
    tick();
    vectors++;
    if (doutb[0] !== 8'hA5 || doutb_vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_read: got %h/%b expected a5/1", doutb[0], doutb_vld[0]);
    end
    rdb[0] = 1'b0;
    tick();
    vectors++;
    if (doutb[0] !== 8'hA5 || doutb_vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_hold: got %h/%b expected a5/0", doutb[0], doutb_vld[0]);
    end
  endtask

  task automatic test_collision();
    for (int d = 0; d < 2; d++) begin
      wea[d] = 1'b1; addra[d] = 4'd7; dina[d] = 8'h11;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      dina[d] = 8'h3C; rdb[d] = 1'b1; addrb[d] = 4'd7;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] want;
      want = byp(d) ? 8'h3C : 8'h11;
      vectors++;
      if (doutb[d] !== want || doutb_vld[d] !== 1'b1) begin
        errors++;
        $display("FAIL collision[%0d]: got %h/%b expected %h/1", d, doutb[d], doutb_vld[d], want);
      end
      idle_inputs(d);
    end
    rdb[0] = 1'b1; rdb[1] = 1'b1; addrb[0] = 4'd7; addrb[1] = 4'd7;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (doutb[d] !== 8'h3C) begin
        errors++;
        $display("FAIL collision_after[%0d]: got %h expected 3c", d, doutb[d]);
      end
      idle_inputs(d);
    end
  endtask

  task automatic test_clear_during();
    int n;
    wea[0] = 1'b1; addra[0] = 4'd2; dina[0] = 8'h42;
    tick();
    wea[0] = 1'b0; clr_req[0] = 1'b1;
    tick();
    clr_req[0] = 1'b0;
    n = 0;
    while (clr_busy[0] === 1'b1 && n < 64) begin
      wea[0] = (n == 2); addra[0] = 4'd2; dina[0] = 8'hFF;
      clr_req[0] = (n == 4);
      rdb[0] = (n == 6); addrb[0] = 4'd2;
      n++;
      tick();
      if (n == 7) begin
        vectors++;
        if (doutb_vld[0] !== 1'b0 || doutb[0] !== exp_dout[0]) begin
          errors++;
          $display("FAIL busy_read: got %h/%b expected %h/0", doutb[0], doutb_vld[0], exp_dout[0]);
        end
      end
    end
    idle_inputs(0);
    vectors++;
    if (n != 16) begin
      errors++;
      $display("FAIL sweep_width: got %0d cycles expected 16", n);
    end
    rdb[0] = 1'b1; addrb[0] = 4'd2;
    tick();
    vectors++;
    if (doutb[0] !== 8'h00 || doutb_vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_dropped: got %h/%b expected 00/1", doutb[0], doutb_vld[0]);
    end
    idle_inputs(0);
  endtask

  task automatic test_out_of_range();
    wea[1] = 1'b1; addra[1] = 4'd13; dina[1] = 8'h77;
    tick();
    wea[1] = 1'b0; rdb[1] = 1'b1; addrb[1] = 4'd13;
    tick();
    vectors++;
    if (doutb[1] !== 8'h00 || doutb_vld[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got %h/%b expected 00/1", doutb[1], doutb_vld[1]);
    end
    for (int i = 0; i < 12; i++) begin
      addrb[1] = 4'(i);
      tick();
      vectors++;
      if (doutb[1] !== mdl[1][i] || doutb_vld[1] !== 1'b1) begin
        errors++;
        $display("FAIL oor_untouched[%0d]: got %h/%b expected %h/1", i, doutb[1], doutb_vld[1], mdl[1][i]);
      end
    end
    idle_inputs(1);
  endtask

  task automatic test_rst_mid_sweep();
    clr_req[0] = 1'b1; clr_req[1] = 1'b1;
    tick();
    clr_req[0] = 1'b0; clr_req[1] = 1'b0;
    repeat (5) tick();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    vectors++;
    if (clr_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort_noauto: got %b expected 0", clr_busy[1]);
    end
    begin
      int n = 0;
      while (clr_busy[0] === 1'b1 && n < 64) begin n++; tick(); end
      vectors++;
      if (n != 16) begin
        errors++;
        $display("FAIL rst_restart_width: got %0d cycles expected 16", n);
      end
    end
    // DUT 1 memory was partially cleared then aborted: re-sweep for a clean image.
    clr_req[1] = 1'b1;
    tick();
    clr_req[1] = 1'b0;
    repeat (14) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        wea[d]     = ($urandom_range(0, 1) == 1);
        rdb[d]     = ($urandom_range(0, 2) != 0);
        addra[d]   = 4'($urandom_range(0, 15));
        addrb[d]   = ($urandom_range(0, 3) == 0) ? addra[d] : 4'($urandom_range(0, 15));
        dina[d]    = 8'($urandom);
        clr_req[d] = ($urandom_range(0, 59) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (doutb_vld[d] !== exp_vld[d] || doutb[d] !== exp_dout[d] || clr_busy[d] !== exp_busy[d]) begin
          errors++;
          $display("FAIL random[%0d] c%0d: got %h/%b/%b expected %h/%b/%b", d, c,
                   doutb[d], doutb_vld[d], clr_busy[d], exp_dout[d], exp_vld[d], exp_busy[d]);
        end
      end
    end
    idle_inputs(0);
    idle_inputs(1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      rst[d] = 1'b1;
      sweep[d] = -1;
      exp_dout[d] = '0; exp_vld[d] = 1'b0; exp_busy[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_collision();
    test_clear_during();
    test_out_of_range();
    test_rst_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
